// File: rtl/nios2_debug_slave_sysclk_cmdq_if.sv
// nios2_debug_slave_sysclk_cmdq_if: tck-side inputs, command handshake and decoded outputs of the debug slave
interface nios2_debug_slave_sysclk_cmdq_if #(
  parameter int IR_WIDTH = 2,
  parameter int SR_WIDTH = 38,
  parameter int COUNT_WIDTH = 8
);
  logic [IR_WIDTH-1:0] ir_in;
  logic [SR_WIDTH-1:0] sr;
  logic vs_uir;
  logic vs_udr;
  logic cmd_ready;
  logic clr_overrun;
  logic [SR_WIDTH-1:0] jdo;
  logic [IR_WIDTH-1:0] ir_q;
  logic [(1<<IR_WIDTH)-1:0] take_action;
  logic [(1<<IR_WIDTH)-1:0] take_no_action;
  logic cmd_valid;
  logic overrun;
  logic [COUNT_WIDTH-1:0] update_count;
  modport master (
    output ir_in, sr, vs_uir, vs_udr, cmd_ready, clr_overrun,
    input jdo, ir_q, take_action, take_no_action, cmd_valid, overrun, update_count
  );
  modport slave (
    input ir_in, sr, vs_uir, vs_udr, cmd_ready, clr_overrun,
    output jdo, ir_q, take_action, take_no_action, cmd_valid, overrun, update_count
  );
endinterface

// File: rtl/nios2_debug_slave_sysclk_cmdq.sv
// nios2_debug_slave_sysclk_cmdq: syncs tck update strobes into clk, latches IR/DR into a one-entry command slot
module nios2_debug_slave_sysclk_cmdq #(
  parameter int IR_WIDTH = 2,
  parameter int SR_WIDTH = 38,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT = 34,
  parameter int COUNT_WIDTH = 8
) (
  input logic clk,
  input logic reset,
  nios2_debug_slave_sysclk_cmdq_if.slave bus
);
  localparam int N = 1 << IR_WIDTH;
  logic [SYNC_STAGES-1:0] uir_sync, udr_sync;
  logic uir_hist, udr_hist;
  logic uir_evt, udr_evt, accept, drop;
  logic [N-1:0] sel;
  always_ff @(posedge clk) begin
    if (reset) begin
      uir_sync <= '0;
      udr_sync <= '0;
      uir_hist <= 1'b0;
      udr_hist <= 1'b0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
      uir_hist <= uir_sync[SYNC_STAGES-1];
      udr_hist <= udr_sync[SYNC_STAGES-1];
    end
  end
  always_comb begin
    uir_evt = uir_sync[SYNC_STAGES-1] & ~uir_hist;
    udr_evt = udr_sync[SYNC_STAGES-1] & ~udr_hist;
    accept = udr_evt & (~bus.cmd_valid | bus.cmd_ready);
    drop = udr_evt & bus.cmd_valid & ~bus.cmd_ready;
    sel = N'(1) << bus.ir_q;
  end
  // decode uses the current ir_q, so a simultaneous IR update only affects the next command
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.jdo <= '0;
      bus.ir_q <= '0;
      bus.take_action <= '0;
      bus.take_no_action <= '0;
      bus.cmd_valid <= 1'b0;
      bus.overrun <= 1'b0;
      bus.update_count <= '0;
    end else begin
      if (uir_evt) bus.ir_q <= bus.ir_in;
      if (accept) bus.jdo <= bus.sr;
      bus.take_action <= (accept && bus.sr[ACT_BIT]) ? sel : '0;
      bus.take_no_action <= (accept && !bus.sr[ACT_BIT]) ? sel : '0;
      bus.cmd_valid <= accept | (bus.cmd_valid & ~bus.cmd_ready);
      bus.overrun <= drop | (bus.overrun & ~bus.clr_overrun);
      bus.update_count <= bus.update_count + COUNT_WIDTH'(accept);
    end
  end
endmodule

// File: tb/tb_nios2_debug_slave_sysclk_cmdq.sv
// tb_nios2_debug_slave_sysclk_cmdq: scoreboard bench for the debug slave command register
module tb_nios2_debug_slave_sysclk_cmdq;
  typedef struct packed {
    logic [37:0] jdo;
    logic [3:0] ta;
    logic [3:0] tna;
    logic [7:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  exp_t exp_m;
  logic [7:0] exp_cnt = '0;
  logic [1:0] model_ir = '0;
  nios2_debug_slave_sysclk_cmdq_if #(.IR_WIDTH(2), .SR_WIDTH(38), .COUNT_WIDTH(8)) bus ();
  nios2_debug_slave_sysclk_cmdq #(
    .IR_WIDTH(2), .SR_WIDTH(38), .SYNC_STAGES(2), .ACT_BIT(34), .COUNT_WIDTH(8)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!reset && (bus.take_action | bus.take_no_action) != 4'b0) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse ta=%b tna=%b jdo=%h", bus.take_action, bus.take_no_action, bus.jdo);
      end else begin
        exp_m = sb.pop_front();
        if ({bus.jdo, bus.take_action, bus.take_no_action, bus.update_count} !== exp_m) begin
          failures++;
          $display("FAIL pulse_cmd got jdo=%h ta=%b tna=%b cnt=%0d want jdo=%h ta=%b tna=%b cnt=%0d",
            bus.jdo, bus.take_action, bus.take_no_action, bus.update_count,
            exp_m.jdo, exp_m.ta, exp_m.tna, exp_m.cnt);
        end
      end
    end
  end
  function automatic void push_exp(input logic [37:0] d, input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    exp_cnt = exp_cnt + 8'd1;
    sb.push_back('{jdo: d, ta: d[34] ? oh : 4'b0, tna: d[34] ? 4'b0 : oh, cnt: exp_cnt});
  endfunction
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_cnt = '0;
    model_ir = '0;
  endtask
  task automatic send(input logic [37:0] d, input bit acc);
    bus.sr = d;
    bus.vs_udr = 1'b1;
    if (acc) push_exp(d, model_ir);
    repeat (4) @(negedge clk);
    bus.vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic set_ir(input logic [1:0] v);
    bus.ir_in = v;
    bus.vs_uir = 1'b1;
    repeat (4) @(negedge clk);
    bus.vs_uir = 1'b0;
    repeat (4) @(negedge clk);
    model_ir = v;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.jdo, bus.ir_q, bus.take_action, bus.take_no_action} !== 48'b0) begin
      failures++;
      $display("FAIL reset_data jdo=%h ir_q=%b ta=%b tna=%b want 0", bus.jdo, bus.ir_q, bus.take_action, bus.take_no_action);
    end
    checks++;
    if ({bus.cmd_valid, bus.overrun, bus.update_count} !== 10'b0) begin
      failures++;
      $display("FAIL reset_ctrl valid=%b overrun=%b cnt=%0d want 0", bus.cmd_valid, bus.overrun, bus.update_count);
    end
  endtask
  task automatic test_ir();
    bus.ir_in = 2'd1;
    bus.vs_uir = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (bus.ir_q !== 2'd0) begin failures++; $display("FAIL ir_early got=%0d want 0", bus.ir_q); end
    @(posedge clk); #1;
    checks++;
    if (bus.ir_q !== 2'd1) begin failures++; $display("FAIL ir_latch got=%0d want 1", bus.ir_q); end
    repeat (3) @(negedge clk);
    bus.vs_uir = 1'b0;
    repeat (4) @(negedge clk);
    model_ir = 2'd1;
  endtask
  task automatic test_action();
    bus.cmd_ready = 1'b0;
    bus.sr = 38'h4_0000_00AA;
    bus.vs_udr = 1'b1;
    push_exp(38'h4_0000_00AA, model_ir);
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (bus.take_action !== 4'b0) begin failures++; $display("FAIL action_early got=%b want 0000", bus.take_action); end
    @(posedge clk); #1;
    checks++;
    if (bus.take_action !== 4'b0010) begin failures++; $display("FAIL action_latency got=%b want 0010", bus.take_action); end
    @(posedge clk); #1;
    checks++;
    if ((bus.take_action | bus.take_no_action) !== 4'b0) begin
      failures++;
      $display("FAIL action_width got=%b want 0000", bus.take_action | bus.take_no_action);
    end
    checks++;
    if ({bus.cmd_valid, bus.update_count} !== {1'b1, 8'd1}) begin
      failures++;
      $display("FAIL action_state valid=%b cnt=%0d want 1 1", bus.cmd_valid, bus.update_count);
    end
    repeat (2) @(negedge clk);
    bus.vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_no_action();
    bus.cmd_ready = 1'b1;
    send(38'h0_1234_5678, 1'b1);
    checks++;
    if ({bus.cmd_valid, bus.update_count, bus.jdo} !== {1'b0, 8'd2, 38'h0_1234_5678}) begin
      failures++;
      $display("FAIL no_action_state valid=%b cnt=%0d jdo=%h want 0 2 0012345678", bus.cmd_valid, bus.update_count, bus.jdo);
    end
  endtask
  task automatic test_overrun();
    bus.cmd_ready = 1'b0;
    send(38'h4_AAAA_0001, 1'b1);
    send(38'h0_BBBB_0002, 1'b0);
    checks++;
    if ({bus.jdo, bus.overrun, bus.cmd_valid, bus.update_count} !== {38'h4_AAAA_0001, 1'b1, 1'b1, 8'd3}) begin
      failures++;
      $display("FAIL overrun_drop jdo=%h ovr=%b valid=%b cnt=%0d want 4aaaa0001 1 1 3",
        bus.jdo, bus.overrun, bus.cmd_valid, bus.update_count);
    end
    bus.clr_overrun = 1'b1;
    @(negedge clk);
    bus.clr_overrun = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b want 0", bus.overrun); end
    bus.sr = 38'h0_CCCC_0003;
    bus.vs_udr = 1'b1;
    push_exp(38'h0_CCCC_0003, model_ir);
    repeat (2) @(negedge clk);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    checks++;
    if ({bus.jdo, bus.overrun, bus.cmd_valid, bus.update_count} !== {38'h0_CCCC_0003, 1'b0, 1'b1, 8'd4}) begin
      failures++;
      $display("FAIL ready_same_cycle jdo=%h ovr=%b valid=%b cnt=%0d want 0cccc0003 0 1 4",
        bus.jdo, bus.overrun, bus.cmd_valid, bus.update_count);
    end
    repeat (2) @(negedge clk);
    bus.vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL overrun_pending got=%0d want 0", sb.size()); end
  endtask
  task automatic test_simultaneous();
    bus.cmd_ready = 1'b1;
    set_ir(2'd0);
    bus.ir_in = 2'd3;
    bus.sr = 38'h4_0000_0011;
    bus.vs_uir = 1'b1;
    bus.vs_udr = 1'b1;
    push_exp(38'h4_0000_0011, 2'd0);
    repeat (4) @(negedge clk);
    bus.vs_uir = 1'b0;
    bus.vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.ir_q !== 2'd3) begin failures++; $display("FAIL simul_ir got=%0d want 3", bus.ir_q); end
    model_ir = 2'd3;
    send(38'h0_0000_0022, 1'b1);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL simul_pending got=%0d want 0", sb.size()); end
  endtask
  task automatic test_wrap();
    do_reset();
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 255; i++) send({i[0], 3'b0, i[1], i[32:0]}, 1'b1);
    checks++;
    if (bus.update_count !== 8'hFF) begin failures++; $display("FAIL wrap_255 got=%0d want 255", bus.update_count); end
    send(38'h4_0000_0100, 1'b1);
    checks++;
    if (bus.update_count !== 8'h00) begin failures++; $display("FAIL wrap_0 got=%0d want 0", bus.update_count); end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL wrap_pending got=%0d want 0", sb.size()); end
  endtask
  task automatic test_reset_mid();
    bus.cmd_ready = 1'b0;
    send(38'h4_1111_1111, 1'b1);
    bus.sr = 38'h4_2222_2222;
    bus.vs_udr = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.vs_udr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_cnt = '0;
    model_ir = '0;
    repeat (8) @(negedge clk);
    checks++;
    if ({bus.jdo, bus.cmd_valid, bus.overrun, bus.update_count, bus.ir_q} !== 50'b0) begin
      failures++;
      $display("FAIL reset_mid jdo=%h valid=%b ovr=%b cnt=%0d ir=%0d want 0",
        bus.jdo, bus.cmd_valid, bus.overrun, bus.update_count, bus.ir_q);
    end
    bus.sr = 38'h0_3333_3333;
    bus.vs_udr = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    push_exp(38'h0_3333_3333, 2'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    bus.vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.update_count, bus.cmd_valid, bus.jdo} !== {8'd1, 1'b1, 38'h0_3333_3333}) begin
      failures++;
      $display("FAIL held_through_reset cnt=%0d valid=%b jdo=%h want 1 1 0333333333", bus.update_count, bus.cmd_valid, bus.jdo);
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL held_pending got=%0d want 0", sb.size()); end
  endtask
  initial begin
    bus.ir_in = '0;
    bus.sr = '0;
    bus.vs_uir = 1'b0;
    bus.vs_udr = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.clr_overrun = 1'b0;
    test_reset();
    test_ir();
    test_action();
    test_no_action();
    test_overrun();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
